lock_score_ctrl: RTL

LOCK_SCORE_CTRL -- requirements
Module: lock_score_ctrl

---
 rtl/lock_score_ctrl_pkg.sv | 37 +++
 rtl/lock_score_ctrl_score_calc.sv | 85 ++++++++
 rtl/lock_score_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lock_score_ctrl_pkg.sv
// Shared definitions for the lock/score controller: FSM states, base-score
// table constants and small helpers used by the controller and the calculator.
package lock_score_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_TRACK      = 2'd0,
    ST_WAIT_LINES = 2'd1,
    ST_CALC       = 2'd2,
    ST_OUT        = 2'd3
  } state_e;

  // Normal clear table (lines 0..4)
  localparam logic [11:0] BASE_NORM_0 = 12'd0;
  localparam logic [11:0] BASE_NORM_1 = 12'd100;
  localparam logic [11:0] BASE_NORM_2 = 12'd300;
  localparam logic [11:0] BASE_NORM_3 = 12'd500;
  localparam logic [11:0] BASE_NORM_4 = 12'd800;

  // Full T-spin table (lines 0..3)
  localparam logic [11:0] BASE_TSPIN_0 = 12'd400;
  localparam logic [11:0] BASE_TSPIN_1 = 12'd800;
  localparam logic [11:0] BASE_TSPIN_2 = 12'd1200;
  localparam logic [11:0] BASE_TSPIN_3 = 12'd1600;

  // Mini / non-T spin table (lines 0..2); 3+ lines fall back to the normal table
  localparam logic [11:0] BASE_MINI_0 = 12'd100;
  localparam logic [11:0] BASE_MINI_1 = 12'd200;
  localparam logic [11:0] BASE_MINI_2 = 12'd400;

  localparam logic [11:0] COMBO_STEP = 12'd50;

  // No more than four rows can clear at once; larger reports are clamped.
  function automatic logic [2:0] clamp_lines(input logic [2:0] raw);
    return (raw > 3'd4) ? 3'd4 : raw;
  endfunction

endpackage

// File: rtl/lock_score_ctrl_score_calc.sv
// Combinational award arithmetic: base table lookup, back-to-back bonus,
// combo counter/bonus and level multiplier.
module score_calc
  import lock_score_ctrl_pkg::*;
#(
  parameter int COMBO_MAX = 31
) (
  input  logic        t_spin_i,
  input  logic        t_spin_mini_i,
  input  logic        other_spin_i,
  input  logic [2:0]  lines_i,
  input  logic [3:0]  level_i,
  input  logic        b2b_i,
  input  logic [4:0]  combo_i,
  output logic [15:0] points_o,
  output logic        b2b_o,
  output logic [4:0]  combo_o
);

  localparam logic [4:0] COMBO_SAT = 5'(COMBO_MAX);

  function automatic logic [4:0] sat_inc(input logic [4:0] cur);
    return (cur >= COMBO_SAT) ? COMBO_SAT : cur + 5'd1;
  endfunction

  function automatic logic [11:0] norm_base(input logic [2:0] lines);
    case (lines)
      3'd0:    return BASE_NORM_0;
      3'd1:    return BASE_NORM_1;
      3'd2:    return BASE_NORM_2;
      3'd3:    return BASE_NORM_3;
      default: return BASE_NORM_4;
    endcase
  endfunction

  logic        any_spin;
  logic        difficult;
  logic [11:0] base;
  logic [11:0] base_b2b;
  logic [11:0] combo_m1;
  logic [11:0] combo_bonus;
  logic [12:0] sum;
  logic [4:0]  lvl_mul;
  logic [15:0] prod;

  // Base lookup, B2B/combo update and final multiply
  always_comb begin
    any_spin  = t_spin_i | t_spin_mini_i | other_spin_i;
    difficult = (lines_i == 3'd4) || ((lines_i != 3'd0) && any_spin);

    // t_spin wins over mini; a 4-line T-spin cannot happen, use the normal table
    base = norm_base(lines_i);
    if (t_spin_i) begin
      case (lines_i)
        3'd0:    base = BASE_TSPIN_0;
        3'd1:    base = BASE_TSPIN_1;
        3'd2:    base = BASE_TSPIN_2;
        3'd3:    base = BASE_TSPIN_3;
        default: base = norm_base(lines_i);
      endcase
    end else if (t_spin_mini_i || other_spin_i) begin
      case (lines_i)
        3'd0:    base = BASE_MINI_0;
        3'd1:    base = BASE_MINI_1;
        3'd2:    base = BASE_MINI_2;
        default: base = norm_base(lines_i);
      endcase
    end

    base_b2b = (difficult && b2b_i) ? base + (base >> 1) : base;

    // A zero-line lock keeps the chain armed but breaks the combo
    b2b_o   = (lines_i == 3'd0) ? b2b_i : difficult;
    combo_o = (lines_i == 3'd0) ? 5'd0 : sat_inc(combo_i);

    combo_m1    = {7'd0, combo_o} - 12'd1;
    combo_bonus = (combo_o >= 5'd2) ? combo_m1 * COMBO_STEP : 12'd0;

    sum      = {1'b0, base_b2b} + {1'b0, combo_bonus};
    lvl_mul  = {1'b0, level_i} + 5'd1;
    prod     = {3'd0, sum} * {11'd0, lvl_mul};
    points_o = prod;
  end

endmodule

// File: rtl/lock_score_ctrl.sv
// Lock/score controller: tracks the last successful move for the spin
// detector, sequences a lock through line counting and scoring, and hands
// the award to the consumer with a valid/ready handshake.
module lock_score_ctrl
  import lock_score_ctrl_pkg::*;
#(
  parameter int COMBO_MAX = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rot_evt,
  input  logic [2:0]  rot_kick,
  input  logic        move_evt,
  input  logic        spawn_evt,
  input  logic        lock_evt,
  input  logic        t_spin,
  input  logic        t_spin_mini,
  input  logic        other_spin,
  input  logic        lines_valid,
  input  logic [2:0]  lines_cleared,
  input  logic [3:0]  level,
  output logic        last_move_was_rotation,
  output logic [2:0]  kick_used,
  output logic        award_valid,
  input  logic        award_ready,
  output logic [15:0] award_points,
  output logic        b2b_active,
  output logic [4:0]  combo_count,
  output logic        busy
);

  state_e state_q, state_d;

  logic        rot_q;
  logic [2:0]  kick_q;
  logic        tspin_q, tmini_q, other_q;
  logic [3:0]  level_q;
  logic [2:0]  lines_q;
  logic        b2b_q;
  logic [4:0]  combo_q;
  logic [15:0] points_q;

  logic [15:0] calc_points;
  logic        calc_b2b;
  logic [4:0]  calc_combo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_TRACK;
    else     state_q <= state_d;
  end

  // Next-state logic; WAIT_LINES has no timeout by design
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TRACK:      if (lock_evt)                 state_d = ST_WAIT_LINES;
      ST_WAIT_LINES: if (lines_valid)              state_d = ST_CALC;
      ST_CALC:                                     state_d = ST_OUT;
      ST_OUT:        if (award_ready)              state_d = ST_TRACK;
      default:                                     state_d = ST_TRACK;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    busy        = (state_q != ST_TRACK);
    award_valid = (state_q == ST_OUT);
  end

  // Move tracker; a lock, shift or spawn clears it and outranks a rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q  <= 1'b0;
      kick_q <= 3'd0;
    end else if (state_q == ST_TRACK) begin
      if (lock_evt || move_evt || spawn_evt) begin
        rot_q  <= 1'b0;
        kick_q <= 3'd0;
      end else if (rot_evt) begin
        rot_q  <= 1'b1;
        kick_q <= rot_kick;
      end
    end
  end

  // Capture spin flags and level at lock, line count when it arrives
  always_ff @(posedge clk) begin
    if (state_q == ST_TRACK && lock_evt) begin
      tspin_q <= t_spin;
      tmini_q <= t_spin_mini;
      other_q <= other_spin;
      level_q <= level;
    end
    if (state_q == ST_WAIT_LINES && lines_valid) begin
      lines_q <= clamp_lines(lines_cleared);
    end
  end

  score_calc #(
    .COMBO_MAX (COMBO_MAX)
  ) u_score_calc (
    .t_spin_i      (tspin_q),
    .t_spin_mini_i (tmini_q),
    .other_spin_i  (other_q),
    .lines_i       (lines_q),
    .level_i       (level_q),
    .b2b_i         (b2b_q),
    .combo_i       (combo_q),
    .points_o      (calc_points),
    .b2b_o         (calc_b2b),
    .combo_o       (calc_combo)
  );

  // Commit award and chain state on the CALC->OUT edge
  always_ff @(posedge clk) begin
    if (rst) begin
      b2b_q    <= 1'b0;
      combo_q  <= 5'd0;
      points_q <= 16'd0;
    end else if (state_q == ST_CALC) begin
      b2b_q    <= calc_b2b;
      combo_q  <= calc_combo;
      points_q <= calc_points;
    end
  end

  assign last_move_was_rotation = rot_q;
  assign kick_used              = kick_q;
  assign award_points           = points_q;
  assign b2b_active             = b2b_q;
  assign combo_count            = combo_q;

endmodule
